stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, W-bit valid/ready stream multiplexer with a registered output, round-robin or forced-select arbitration, and packet locking on a `last` flag. It is the sequential, scalable successor to the team's 4:1 select mux and sits between multiple packet producers and a single downstream consumer. One beat per cycle of throughput, one cycle of latency.

## Interface
- `N`, default 4: number of input channels; N ≥ 2.
- `W`, default 8: data width per channel.
- `SW`, default $clog2(N): select width (derived; do not override).
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, N*W: channel i occupies bits [i*W +: W].
- `in_valid`, input, N: per-channel beat valid.
- `in_last`, input, N: per-channel end-of-packet flag, qualified by in_valid.
- `in_ready`, output, N: per-channel accept; at most one bit is high.
- `sel_mode`, input, 1: 0 selects round-robin; 1 selects forced.
- `sel`, input, SW: channel used when sel_mode=1; values ≥ N select nothing.
- `out_data`, output, W: registered data.
- `out_valid`, output, 1: registered valid.
- `out_last`, output, 1: registered last.
- `out_sel`, output, SW: channel index of the beat currently held on the output.
- `out_ready`, input, 1: downstream accept.

## Operation
- Output register: `load_en = !out_valid || out_ready`. The register loads when a granted input beat transfers. If load_en=1 and no transfer occurs, out_valid clears.
- Grant `g`, combinational:
  - IDLE, sel_mode=0: the first channel with in_valid=1, scanning upward from ptr+1 (mod N).
  - IDLE, sel_mode=1: g=sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - LOCKED: g=lock_ch if in_valid[lock_ch]=1; otherwise no grant. sel_mode and sel are ignored.
- `in_ready[i] = load_en && grant valid && (i == g)`. in_ready may depend combinationally on out_ready.
- A transfer on g occurs when in_valid[g] && in_ready[g]. On transfer, out_data, out_last and out_sel load from channel g, and out_valid=1.
- State machine, 2 states:
  - IDLE → LOCKED: transfer with in_last=0; lock_ch=g.
  - LOCKED → IDLE: transfer on lock_ch with in_last=1.
  - IDLE → IDLE: transfer with in_last=1, or no transfer.
  - LOCKED → LOCKED: any other case, including in_valid[lock_ch]=0 bubbles. Bubbles never release the lock.
- Round-robin pointer: ptr updates to g on every transfer with in_last=1, in either mode. Fairness is therefore per packet. ptr does not change on other cycles.
- A mode or sel change while LOCKED takes effect only at the first IDLE cycle.
- Simultaneous events: an output beat leaving and a new beat loading in the same cycle is normal full-rate operation. No beat is dropped or duplicated.

## Timing
- Reset values (the cycle after rst is sampled high): out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, ptr=N-1 (channel 0 has first priority), lock_ch=0.
- in_ready is forced to all-zero while rst=1.
- Reset mid-packet drops the lock and clears the output register. The partial packet is discarded without flushing.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Arbitration switches channels with zero bubble cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_* hold stable and every in_ready bit is 0.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111. Required: in_ready=0 and all outputs 0 throughout. After release, the first out_sel=0 appears one cycle after the first accept.
- Round-robin, single-beat packets: N=4, all valid, in_last=1111, out_ready=1, data on channel i = 8'hA0+i. Required: out_sel sequence 0,1,2,3,0 on consecutive cycles, with data A0,A1,A2,A3,A0.
- Packet lock: ptr=1. ch2 sends 3 beats (last on the 3rd) with a 1-cycle in_valid gap after beat 1, while ch0 and ch3 stay valid. Required: out_sel=2 for all 3 beats, a bubble on out_valid during the gap, then ch3 next, then ch0.
- Backpressure: drop out_ready for 3 cycles while out_valid=1. Required: out_data stable, in_ready=0000. After release the stream resumes with no lost or duplicated beat, checked by a scoreboard against the input order.
- Forced mode: sel_mode=1, sel=3, ch3 idle, ch0 valid. Required: no transfer. Then ch3 sends 2 beats and sel changes to 0 after beat 1. Required: both ch3 beats forwarded, then ch0. Also sel=3 with N=3: no transfer ever.
- Reset mid-packet: assert rst in LOCKED after beat 2 of 4. Required: out_valid=0 the next cycle, state IDLE, ptr=N-1. After release, channel 0 wins if valid.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with a registered output stage.
// Round-robin or forced-select arbitration; a channel keeps the output until its packet's last beat.
module stream_mux_rr #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   input  logic            sel_mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   output logic            out_last,
   output logic [SW-1:0]   out_sel,
   input  logic            out_ready
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SW-1:0]   r_ptr;
   logic [SW-1:0]   r_lock_ch;
   logic [W-1:0]    r_out_data;
   logic            r_out_valid;
   logic            r_out_last;
   logic [SW-1:0]   r_out_sel;

   logic [SW-1:0]   w_g;
   logic            w_gnt;
   logic            w_load_en;
   logic            w_xfer;
   logic [W-1:0]    w_g_data;
   logic            w_g_last;
   int unsigned     w_dist;
   int unsigned     w_best;

   assign w_load_en = !r_out_valid || out_ready;
   assign w_xfer    = w_gnt && w_load_en;

   // Grant: locked channel, forced select, or nearest valid channel after r_ptr.
   always_comb begin
      w_g    = '0;
      w_gnt  = 1'b0;
      w_dist = 0;
      w_best = N;
      if (r_state == ST_LOCKED) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (SW'(i) == r_lock_ch && in_valid[i]) begin
               w_g   = SW'(i);
               w_gnt = 1'b1;
            end
         end
      end else if (sel_mode) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (SW'(i) == sel && in_valid[i]) begin
               w_g   = SW'(i);
               w_gnt = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            w_dist = (i + 2 * N - 32'(r_ptr) - 1) % N;
            if (in_valid[i] && w_dist < w_best) begin
               w_best = w_dist;
               w_g    = SW'(i);
               w_gnt  = 1'b1;
            end
         end
      end
   end

   // Payload of the granted channel and the one-hot accept.
   always_comb begin
      w_g_data = '0;
      w_g_last = 1'b0;
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (SW'(i) == w_g) begin
            w_g_data    = in_data[i*W +: W];
            w_g_last    = in_last[i];
            in_ready[i] = w_xfer && !rst;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_IDLE) begin
         if (w_xfer && !w_g_last) w_state_nxt = ST_LOCKED;
      end else begin
         if (w_xfer && w_g_last) w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Output register, round-robin pointer and lock owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_sel   <= '0;
         r_ptr       <= SW'(N - 1);
         r_lock_ch   <= '0;
      end else begin
         if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
               r_out_data <= w_g_data;
               r_out_last <= w_g_last;
               r_out_sel  <= w_g;
            end
         end
         if (w_xfer && w_g_last) r_ptr <= w_g;
         if (r_state == ST_IDLE && w_xfer && !w_g_last) r_lock_ch <= w_g;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, round-robin, packet lock, backpressure, forced select, reset mid-packet.
module tb_stream_mux_rr;

   logic        clk;
   logic        rst;
   logic [7:0]  dat [4];
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        sel_mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_sel;
   logic        out_ready;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_last3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_last3;
   logic [1:0]  out_sel3;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] got [$];
   logic [7:0] exp_q [$];

   assign in_data = {dat[3], dat[2], dat[1], dat[0]};

   stream_mux_rr #(.N(4), .W(8)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .sel_mode(sel_mode), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel), .out_ready(out_ready)
   );

   // Three-channel instance: sel=3 is out of range and must never grant.
   stream_mux_rr #(.N(3), .W(8)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
      .in_ready(in_ready3), .sel_mode(1'b1), .sel(sel3), .out_data(out_data3),
      .out_valid(out_valid3), .out_last(out_last3), .out_sel(out_sel3), .out_ready(1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares {valid,last,sel,data} in one go.
   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic [1:0] s);
      chk(tag, 32'({out_valid, out_last, out_sel, out_data}), 32'({v, l, s, d}));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic [0:7] rdy_pat;
      rdy_pat   = 8'b1100_0111;
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      sel_mode  = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);
      in_data3  = 24'h332211;
      in_valid3 = 3'b111;
      in_last3  = 3'b111;
      sel3      = 2'd3;

      // Reset held two cycles with all inputs valid
      for (int r = 0; r < 2; r++) begin
         cyc();
         chk("rst_ready", 32'(in_ready), 32'h0);
         chk("rst_out", 32'({out_valid, out_last, out_sel, out_data}), 32'h0);
      end

      // Round-robin with single-beat packets: 0,1,2,3,0
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("rr_ready", 32'(in_ready), 32'(1) << (k % 4));
         cyc();
         chk_out("rr_out", 1'b1, 8'hA0 + 8'(k % 4), 1'b1, 2'(k % 4));
      end
      settle();
      chk("rr_ready_ch1", 32'(in_ready), 32'h2);
      cyc();
      chk_out("rr_out_ch1", 1'b1, 8'hA1, 1'b1, 2'd1);

      // Packet lock on ch2 with a one-cycle gap; ch0 and ch3 stay valid
      in_valid = 4'b1101;
      in_last  = 4'b1001;
      dat[2]   = 8'hB0;
      settle();
      chk("lock_b0_ready", 32'(in_ready), 32'h4);
      cyc();
      chk_out("lock_b0_out", 1'b1, 8'hB0, 1'b0, 2'd2);
      in_valid = 4'b1001;
      settle();
      chk("lock_gap_ready", 32'(in_ready), 32'h0);
      cyc();
      chk("lock_gap_valid", 32'(out_valid), 32'h0);
      in_valid = 4'b1101;
      dat[2]   = 8'hB1;
      settle();
      chk("lock_b1_ready", 32'(in_ready), 32'h4);
      cyc();
      chk_out("lock_b1_out", 1'b1, 8'hB1, 1'b0, 2'd2);
      dat[2]  = 8'hB2;
      in_last = 4'b1101;
      settle();
      chk("lock_b2_ready", 32'(in_ready), 32'h4);
      cyc();
      chk_out("lock_b2_out", 1'b1, 8'hB2, 1'b1, 2'd2);
      in_valid = 4'b1001;
      settle();
      chk("after_lock_ready3", 32'(in_ready), 32'h8);
      cyc();
      chk_out("after_lock_out3", 1'b1, 8'hA3, 1'b1, 2'd3);
      settle();
      chk("after_lock_ready0", 32'(in_ready), 32'h1);
      cyc();
      chk_out("after_lock_out0", 1'b1, 8'hA0, 1'b1, 2'd0);

      // Backpressure: out_ready low for three cycles, consumed beats logged
      in_valid = 4'b1111;
      in_last  = 4'b1111;
      for (int i = 0; i < 4; i++) dat[i] = 8'hC0 + 8'(i);
      for (int k = 0; k < 8; k++) begin
         out_ready = rdy_pat[k];
         settle();
         if (out_valid && out_ready) got.push_back(out_data);
         if (!rdy_pat[k]) chk("bp_ready", 32'(in_ready), 32'h0);
         cyc();
         if (!rdy_pat[k]) chk_out("bp_hold", 1'b1, 8'hC2, 1'b1, 2'd2);
      end
      exp_q = '{8'hA0, 8'hC1, 8'hC2, 8'hC3, 8'hC0};
      chk("sb_count", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk("sb_beat", 32'(got[i]), 32'(exp_q[i]));
      chk_out("bp_tail", 1'b1, 8'hC1, 1'b1, 2'd1);

      // Forced select on an idle channel: no transfer
      sel_mode = 1'b1;
      sel      = 2'd3;
      in_valid = 4'b0001;
      for (int i = 0; i < 4; i++) dat[i] = 8'hD0 + 8'(i);
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("frc_idle_ready", 32'(in_ready), 32'h0);
         cyc();
         chk("frc_idle_valid", 32'(out_valid), 32'h0);
      end
      chk("n3_ready", 32'(in_ready3), 32'h0);
      chk("n3_valid", 32'(out_valid3), 32'h0);

      // ch3 sends two beats; sel moves to 0 after the first
      in_valid = 4'b1001;
      in_last  = 4'b0111;
      dat[3]   = 8'hE0;
      settle();
      chk("frc_e0_ready", 32'(in_ready), 32'h8);
      cyc();
      chk_out("frc_e0_out", 1'b1, 8'hE0, 1'b0, 2'd3);
      sel     = 2'd0;
      dat[3]  = 8'hE1;
      in_last = 4'b1111;
      settle();
      chk("frc_e1_ready", 32'(in_ready), 32'h8);
      cyc();
      chk_out("frc_e1_out", 1'b1, 8'hE1, 1'b1, 2'd3);
      in_valid = 4'b0001;
      settle();
      chk("frc_d0_ready", 32'(in_ready), 32'h1);
      cyc();
      chk_out("frc_d0_out", 1'b1, 8'hD0, 1'b1, 2'd0);
      chk("n3_ready_late", 32'(in_ready3), 32'h0);
      chk("n3_valid_late", 32'(out_valid3), 32'h0);

      // Reset in the middle of a ch1 packet
      sel_mode = 1'b0;
      in_valid = 4'b0010;
      in_last  = 4'b0000;
      dat[1]   = 8'hF0;
      settle();
      chk("mid_f0_ready", 32'(in_ready), 32'h2);
      cyc();
      chk_out("mid_f0_out", 1'b1, 8'hF0, 1'b0, 2'd1);
      dat[1] = 8'hF1;
      settle();
      chk("mid_f1_ready", 32'(in_ready), 32'h2);
      cyc();
      chk_out("mid_f1_out", 1'b1, 8'hF1, 1'b0, 2'd1);
      rst      = 1'b1;
      in_valid = 4'b0011;
      in_last  = 4'b0001;
      dat[0]   = 8'h5A;
      dat[1]   = 8'hF2;
      settle();
      chk("mid_rst_ready", 32'(in_ready), 32'h0);
      cyc();
      chk("mid_rst_out", 32'({out_valid, out_last, out_sel, out_data}), 32'h0);
      rst = 1'b0;
      settle();
      chk("mid_post_ready", 32'(in_ready), 32'h1);
      cyc();
      chk_out("mid_post_out", 1'b1, 8'h5A, 1'b1, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
